// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (8N1 by default, LSB first, idle-high line)
// fed by a small write FIFO, so short bursts of bytes can be queued.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
module uart_tx_fifo #(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned StopBits     = 1,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD_ready,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       TxD_done
);

  localparam int unsigned CLKS_PER_BIT = (ClkFrequency + Baud / 2) / Baud;
  localparam int unsigned DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CNT_W        = PTR_W + 1;

  if (ClkFrequency < 4 * Baud) begin : g_bad_baud
    $error("uart_tx_fifo: ClkFrequency must be at least 4*Baud");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
    $error("uart_tx_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of 2 and >= 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy;
`ifdef UART_TX_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  logic [7:0]       r_mem [FifoDepth];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;

  assign TxD_ready = (r_count != CNT_W'(FifoDepth));
  assign w_push    = TxD_start && TxD_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_tick    = (r_div == DIV_W'(CLKS_PER_BIT - 1));

  assign TxD      = r_txd;
  assign TxD_busy = r_busy;
  assign TxD_done = r_done;

  // FIFO storage: written on every accepted strobe, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= TxD_data;
  end

  // FIFO pointers and occupancy; push+pop together leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bit-period divider; held at zero in IDLE so the start bit is edge-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_div <= '0;
    else if (r_state == S_IDLE || w_tick) r_div <= '0;
    else                                  r_div <= r_div + 1'b1;
  end

  // Frame state and line/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (r_state != S_IDLE) || (r_count != '0);
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  // Next-state and next line value; the line is registered, so each
  // transition loads the value of the bit that starts on that edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_txd_nxt    = r_txd;
    w_done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_pop) begin
          w_state_nxt  = S_START;
          w_txd_nxt    = 1'b0;
          w_shift_nxt  = r_mem[r_rd_ptr];
          w_bitcnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = ^r_mem[r_rd_ptr];
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt  = S_DATA;
          w_bitcnt_nxt = '0;
          w_txd_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt  = S_PARITY;
            w_txd_nxt    = r_parity;
`else
            w_state_nxt  = S_STOP;
            w_txd_nxt    = 1'b1;
            w_bitcnt_nxt = '0;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
            w_shift_nxt  = r_shift >> 1;
            w_txd_nxt    = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt  = S_STOP;
          w_txd_nxt    = 1'b1;
          w_bitcnt_nxt = '0;
        end
      end
`endif
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_tick) begin
          // bit counter is reused to count stop-bit periods
          if (r_bitcnt == 3'(StopBits - 1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo at 50 MHz / 5 Mbaud (10 clocks per bit).
// Stimulus pushes expected bytes (with expected frame-start spacing) into a
// scoreboard queue; a line receiver pops and compares each decoded frame.
// Define UART_TX_PARITY_EN to build and check the parity / two-stop-bit variant.
module tb_uart_tx_fifo;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int NB    = 9 + PB + SB;   // start + 8 data + parity + stops
  localparam int FRAME = NB * CPB;      // 100 clocks, 120 with parity build
  localparam int GAP   = FRAME + 1;     // back-to-back frame start spacing

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       TxD_start = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic       TxD_ready, TxD, TxD_busy, TxD_done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int last_fall = 0;

  typedef struct {
    logic [7:0] data;
    int         gap;   // required cycles since previous frame start, 0 = any
  } exp_t;
  exp_t exp_q[$];

  uart_tx_fifo #(
    .ClkFrequency(50000000),
    .Baud        (5000000),
    .StopBits    (SB),
    .FifoDepth   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .TxD_start(TxD_start),
    .TxD_data (TxD_data),
    .TxD_ready(TxD_ready),
    .TxD      (TxD),
    .TxD_busy (TxD_busy),
    .TxD_done (TxD_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int unsigned budget, output bit found);
    found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      tick();
      if (TxD_done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_drain(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      tick();
      if (exp_q.size() == 0 && TxD_busy === 1'b0) ok = 1'b1;
    end
  endtask

  // Line receiver: detects the start edge, samples mid-bit, checks frame.
  initial begin : rx_monitor
    logic          prev;
    bit            active;
    int            cnt;
    int            fall;
    logic [NB-1:0] bits;
    exp_t          e;
    prev   = 1'b1;
    active = 1'b0;
    cnt    = 0;
    fall   = 0;
    bits   = '0;
    forever begin
      tick();
      if (!rst_n) begin
        active = 1'b0;
        prev   = 1'b1;
      end else begin
        if (!active) begin
          if (prev && !TxD) begin
            active = 1'b1;
            cnt    = 0;
            fall   = cyc;
          end
        end else begin
          cnt++;
          if (cnt % CPB == CPB / 2) bits[cnt / CPB] = TxD;
          if (cnt == CPB * (NB - 1) + CPB / 2) begin
            active = 1'b0;
            check("rx_frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("rx_start_bit", bits[0], 0);
              check("rx_data", bits[8:1], e.data);
`ifdef UART_TX_PARITY_EN
              check("rx_parity", bits[9], ^e.data);
`endif
              for (int unsigned k = 9 + PB; k < NB; k++) check("rx_stop_bit", bits[k], 1);
              if (e.gap != 0) check("rx_frame_gap", fall - last_fall, e.gap);
            end
            last_fall = fall;
          end
        end
        prev = TxD;
      end
    end
  end

  // Done pulse monitor: one cycle wide, exactly one frame length after start.
  initial begin : done_monitor
    logic prev_d;
    prev_d = 1'b0;
    forever begin
      tick();
      if (TxD_done === 1'b1) begin
        done_cnt++;
        check("done_timing", cyc - last_fall, FRAME);
        check("done_one_cycle", prev_d, 0);
      end
      prev_d = TxD_done;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit found;
    bit ok;
    int ca;

    // Reset then idle
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("rst_txd", TxD, 1);
      check("rst_ready", TxD_ready, 1);
      check("rst_busy", TxD_busy, 0);
      check("rst_done", TxD_done, 0);
    end
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 50; i++) tick();
    check("idle_txd", TxD, 1);
    check("idle_ready", TxD_ready, 1);
    check("idle_busy", TxD_busy, 0);
    check("idle_no_done", done_cnt, 0);

    // Single byte 0xA5
    exp_q.push_back('{8'hA5, 0});
    TxD_start = 1'b1;
    TxD_data  = 8'hA5;
    tick();
    TxD_start = 1'b0;
    TxD_data  = 8'h5A;
    check("lat_first_edge_txd", TxD, 1);
    tick();
    check("lat_second_edge_txd", TxD, 0);
    check("busy_in_frame", TxD_busy, 1);
    wait_done(200, found);
    check("single_done_seen", found, 1);
    check("busy_at_done", TxD_busy, 1);
    tick();
    check("busy_after_done", TxD_busy, 0);
    check("done_dropped", TxD_done, 0);
    for (int unsigned i = 0; i < 5; i++) tick();

    // Burst of five on consecutive cycles, then a write while full
    for (int unsigned i = 0; i < 5; i++) begin
      exp_q.push_back('{8'(i + 1), (i == 0) ? 0 : GAP});
      TxD_start = 1'b1;
      TxD_data  = 8'(i + 1);
      tick();
      if (i == 3) check("burst_ready_3_queued", TxD_ready, 1);
      if (i == 4) check("burst_ready_full", TxD_ready, 0);
    end
    TxD_data = 8'h06;
    tick();
    TxD_start = 1'b0;
    check("full_write_ignored_ready", TxD_ready, 0);
    wait_drain(6 * GAP + 50, ok);
    check("burst_drained", ok, 1);
    for (int unsigned i = 0; i < 5; i++) tick();

    // Simultaneous push/pop with one entry queued
    exp_q.push_back('{8'h3C, 0});
    TxD_start = 1'b1;
    TxD_data  = 8'h3C;
    tick();
    ca = cyc;
    exp_q.push_back('{8'hC3, GAP});
    TxD_data = 8'hC3;
    tick();
    TxD_start = 1'b0;
    check("pp_first_start", TxD, 0);
    while (cyc < ca + GAP) tick();
    check("pp_stop_idle_cycle", TxD, 1);
    exp_q.push_back('{8'h5A, GAP});
    TxD_start = 1'b1;
    TxD_data  = 8'h5A;
    tick();
    TxD_start = 1'b0;
    check("pp_next_start", TxD, 0);
    check("pp_ready_one_entry", TxD_ready, 1);
    wait_drain(3 * GAP + 50, ok);
    check("pp_drained", ok, 1);
    for (int unsigned i = 0; i < 5; i++) tick();

    // Reset in the middle of data bit 3 of 0x55, with 0x99 queued behind it
    TxD_start = 1'b1;
    TxD_data  = 8'h55;
    tick();
    ca = cyc;
    TxD_data = 8'h99;
    tick();
    TxD_start = 1'b0;
    while (cyc < ca + 46) tick();
    check("mid_bit3_low", TxD, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", TxD, 1);
    check("mid_rst_ready", TxD_ready, 1);
    check("mid_rst_busy", TxD_busy, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", TxD_busy, 0);
    check("post_rst_txd", TxD, 1);
    exp_q.push_back('{8'h0F, 0});
    TxD_start = 1'b1;
    TxD_data  = 8'h0F;
    tick();
    TxD_start = 1'b0;
    wait_drain(GAP + 50, ok);
    check("post_rst_drained", ok, 1);

`ifdef UART_TX_PARITY_EN
    // Parity build: 0x07 has odd weight, so the even parity bit is 1
    for (int unsigned i = 0; i < 5; i++) tick();
    exp_q.push_back('{8'h07, 0});
    TxD_start = 1'b1;
    TxD_data  = 8'h07;
    tick();
    TxD_start = 1'b0;
    wait_drain(GAP + 50, ok);
    check("parity_drained", ok, 1);
`endif

    for (int unsigned i = 0; i < 5; i++) tick();
    check("total_done_pulses", done_cnt, 10 + PB);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
